seg_display_scan: RTL
=====================

// Module: seg_display_scan
// PURPOSE
//  Time-multiplexed driver for the 3-digit 7-segment display. Takes the 12-bit status word from the
//  status encoder (3 hex nibbles) and scans one digit at a time onto the shared cathode bus.
//  Sits between the status logic and the board pins; all outputs are registered.
//  Includes an anti-ghosting blank gap and frame-synchronous input capture (no tearing).
// PARAMETERS
//  DIGIT_CYCLES  50000  clk cycles per digit slot (0.5 ms at 100 MHz); must be >= 2
//  BLANK_CYCLES  1000   cycles at start of each slot with all anodes off; must be < DIGIT_CYCLES
//  HB_FRAMES     128    frames per heartbeat half-period (used only with SEG_DP_HEARTBEAT_EN)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = scan; 0 = display dark, counters held at 0
//  seg_digits   in   12  {digit2, digit1, digit0} hex nibbles; digit0 = rightmost
//  seg_anodes   out  3   active-low digit selects, bit i = digit i
//  seg_cathodes out  8   active-low {dp,g,f,e,d,c,b,a}
//  frame_tick   out  1   1-cycle pulse when a full 3-digit frame completes
// BEHAVIOUR
//  - Reset (async assert, sync release): slot_cnt=0, digit_idx=0, shadow=12'h000, seg_anodes=3'b111,
//    seg_cathodes=8'hFF, frame_tick=0, heartbeat=0.
//  - slot_cnt counts 0..DIGIT_CYCLES-1, wraps to 0; on wrap digit_idx advances 0->1->2->0.
//  - Blank phase: slot_cnt < BLANK_CYCLES -> seg_anodes=3'b111, seg_cathodes=8'hFF.
//  - Drive phase: anode bit digit_idx low, others high; cathodes = decode(shadow nibble digit_idx).
//  - Outputs registered: pins reflect (slot_cnt,digit_idx) of the previous cycle (1-cycle latency).
//  - Frame end: cycle where digit_idx==2 and slot_cnt==DIGIT_CYCLES-1 -> shadow<=seg_digits,
//    frame_tick=1 next cycle. seg_digits changes mid-frame are invisible until the next frame.
//  - Decode (active-low, dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//    A=88 b=83 C=C6 d=A1 E=86 F=8E.
//  - enable=0: slot_cnt/digit_idx forced 0, shadow loads seg_digits every cycle, outputs blank,
//    frame_tick=0. enable rising: scan restarts at digit0 blank phase with the freshest value.
//  - Reset mid-frame: immediate dark outputs; restarts from digit0 with shadow=000 until first frame end.
// CONFIGURATION
//  SEG_DP_HEARTBEAT_EN defined: frame counter counts frame ends 0..HB_FRAMES-1; on wrap heartbeat
//    toggles; dp (cathode bit 7) of digit0 driven low while heartbeat=1 (drive phase only).
//  Not defined: no frame counter, dp bit always 1 on every digit.
// STRUCTURE
//  Shared definitions header: segment code constants (SEG_BLANK=8'hFF, hex glyph table), anode-off
//  constant, and the STATE_* display words already used by the status encoder.
//  Sub-module seg_hex_decode: combinational 4-bit nibble -> 7-bit active-low segments.
//  Top holds slot counter, digit index, shadow register, heartbeat, output registers.
// TESTING  (DIGIT_CYCLES=8, BLANK_CYCLES=2, HB_FRAMES=2)
//  1 Reset then seg_digits=12'h210 held 3 frames -> frame 1 shows 000; from frame 2: digit0 C0,
//    digit1 F9, digit2 A4, each 6 drive cycles after 2 blank cycles, anodes 110/101/011.
//  2 Check frame_tick: exactly one pulse per 24 cycles, first at cycle 24 after reset release.
//  3 Change seg_digits 210->FEd while digit1 is driving -> digit2 still A4 this frame;
//    next frame digits A1/86/8E.
//  4 Drop enable for 5 cycles mid-digit1 with seg_digits=12'h999 -> anodes 111, cathodes FF
//    next cycle; after re-enable 2 blank cycles then digit0 shows 90, no frame_tick while disabled.
//  5 Assert rst_n low mid-drive -> anodes 111 / cathodes FF asynchronously; after release digit0=C0.
//  6 With SEG_DP_HEARTBEAT_EN, digits=000 -> digit0 cathode alternates C0 / 40 every 2 frames;
//    without macro always C0.

Source files
------------

// File: rtl/seg_display_scan_pkg.sv
// seg_display_scan_pkg: shared 7-segment constants, glyph table and status display words
// Contents: SEG_BLANK / ANODES_OFF pin idle values, HEX_GLYPHS active-low
// {dp,g,f,e,d,c,b,a} codes for nibbles 0..F packed LSB-first, STATE_* words shown
// by the status encoder, digit index type and anode select helper.
package seg_display_scan_pkg;
   localparam logic [7:0]   SEG_BLANK  = 8'hFF;
   localparam logic [2:0]   ANODES_OFF = 3'b111;
   localparam logic [127:0] HEX_GLYPHS = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };
   localparam logic [11:0] STATE_IDLE  = 12'h000;
   localparam logic [11:0] STATE_BUSY  = 12'hB05;
   localparam logic [11:0] STATE_DONE  = 12'hD0E;
   localparam logic [11:0] STATE_FAULT = 12'hFA1;
   typedef enum logic [1:0] {DIGIT0, DIGIT1, DIGIT2} digit_t;
   function automatic logic [2:0] anode_sel(digit_t d);
      return ~(3'b001 << d);
   endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low 7-segment pattern
// Ports: nibble (in, 4) hex value; segments (out, 7) active-low {g,f,e,d,c,b,a}.
module seg_hex_decode
   import seg_display_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);
   assign segments = HEX_GLYPHS[{nibble, 3'b000} +: 7];
endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexed 3-digit 7-segment scanner with blank gap and frame-synchronous capture
// Ports: clk, rst_n (async active-low), enable, seg_digits[11:0] {d2,d1,d0},
//        seg_anodes[2:0] active-low digit selects, seg_cathodes[7:0] active-low {dp,g..a},
//        frame_tick 1-cycle pulse per completed frame.
// Optional: SEG_DP_HEARTBEAT_EN blinks digit0's decimal point every HB_FRAMES frames.
module seg_display_scan
   import seg_display_scan_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 1000,
   parameter int HB_FRAMES    = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [11:0] seg_digits,
   output logic [2:0]  seg_anodes,
   output logic [7:0]  seg_cathodes,
   output logic        frame_tick
);
   localparam int CW = $clog2(DIGIT_CYCLES);
   if (DIGIT_CYCLES < 2 || BLANK_CYCLES >= DIGIT_CYCLES || HB_FRAMES < 1) begin : g_bad_params
      $error("seg_display_scan: invalid parameters");
   end
   logic [CW-1:0] slot_cnt;
   digit_t        digit_idx;
   logic [11:0]   shadow;
   logic [6:0]    segments;
   logic          slot_end, frame_end, blank, dp_n;
   assign slot_end  = slot_cnt == CW'(DIGIT_CYCLES - 1);
   assign frame_end = slot_end && digit_idx == DIGIT2;
   assign blank     = slot_cnt < CW'(BLANK_CYCLES);
   seg_hex_decode u_dec (
      .nibble   (shadow[{digit_idx, 2'b00} +: 4]),
      .segments (segments)
   );
`ifdef SEG_DP_HEARTBEAT_EN
   localparam int FW = HB_FRAMES > 1 ? $clog2(HB_FRAMES) : 1;
   logic [FW-1:0] frame_cnt;
   logic          heartbeat;
   logic          hb_wrap;
   assign hb_wrap = frame_cnt == FW'(HB_FRAMES - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         frame_cnt <= '0;
         heartbeat <= 1'b0;
      end else if (enable && frame_end) begin
         frame_cnt <= hb_wrap ? '0 : frame_cnt + 1'b1;
         heartbeat <= hb_wrap ? ~heartbeat : heartbeat;
      end
   assign dp_n = ~(heartbeat && digit_idx == DIGIT0);
`else
   assign dp_n = 1'b1;
`endif
   // Pins are registered from the current (slot_cnt, digit_idx), so they trail the counters by one cycle.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         slot_cnt     <= '0;
         digit_idx    <= DIGIT0;
         shadow       <= 12'h000;
         seg_anodes   <= ANODES_OFF;
         seg_cathodes <= SEG_BLANK;
         frame_tick   <= 1'b0;
      end else if (!enable) begin
         slot_cnt     <= '0;
         digit_idx    <= DIGIT0;
         shadow       <= seg_digits;
         seg_anodes   <= ANODES_OFF;
         seg_cathodes <= SEG_BLANK;
         frame_tick   <= 1'b0;
      end else begin
         slot_cnt     <= slot_end ? '0 : slot_cnt + 1'b1;
         digit_idx    <= !slot_end ? digit_idx : digit_idx == DIGIT2 ? DIGIT0 : digit_t'(digit_idx + 2'd1);
         shadow       <= frame_end ? seg_digits : shadow;
         seg_anodes   <= blank ? ANODES_OFF : anode_sel(digit_idx);
         seg_cathodes <= blank ? SEG_BLANK : {dp_n, segments};
         frame_tick   <= frame_end;
      end
endmodule
